// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: capture-state type and
// default FIFO depth.
package uart_pkg;

    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        LOAD  = 2'b10
    } cap_state_t;

endpackage

// File: rtl/rx_buffer_if.sv
// Consumer-side bus of the receive buffer: pop/clear requests in, head data,
// occupancy and status flags out.
interface rx_buffer_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic          rd_en;
    logic          clr_ovf;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic          overflow;

    // Consumer drives requests and observes the buffer.
    modport master (
        output rd_en,
        output clr_ovf,
        input  rd_data,
        input  empty,
        input  full,
        input  level,
        input  overflow
    );

    // The buffer answers requests and reports its state.
    modport slave (
        input  rd_en,
        input  clr_ovf,
        output rd_data,
        output empty,
        output full,
        output level,
        output overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered first-word-fall-through head,
// registered level/empty/full flags and a sticky overflow bit.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [AW:0]   level_nxt;
    logic [7:0]    head_nxt;
    logic          pop;
    logic          push;
    logic          drop;

    // Decide this cycle's pop/push/drop and the next head and level.
    always_comb begin
        pop        = rd_en && !empty;
        push       = wr && (!full || pop);
        drop       = wr && full && !pop;
        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;

        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + (AW+1)'(1);
        end else if (pop && !push) begin
            level_nxt = level - (AW+1)'(1);
        end

        // Head is registered: when the written byte lands in the slot that
        // becomes the head, forward it instead of reading the stale entry.
        head_nxt = rd_data;
        if (level_nxt != '0) begin
            if (push && (rd_ptr_nxt == wr_ptr)) begin
                head_nxt = wr_data;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, flags, head register and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_ptr_nxt;
            level   <= level_nxt;
            empty   <= (level_nxt == '0);
            full    <= (level_nxt == LEVEL_FULL);
            rd_data <= head_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rx_buffer.sv
// Receive buffer: watches the receiver busy flag and the 8x baud tick,
// captures RHR once per completed frame and queues it in a FIFO.
module rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        bclkx8,
    input  logic        rx_status,
    input  logic [7:0]  RHR,
    rx_buffer_if.slave  bus
);

    cap_state_t state;
    logic       status_prev;
    logic       bclk_prev;
    logic       load_q;
    logic       status_fall;
    logic       bclk_rise;

    assign status_fall = status_prev && !rx_status;
    assign bclk_rise   = bclkx8 && !bclk_prev;

    // Previous-sample copies; reset tracks the live inputs so release
    // never produces a phantom edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            status_prev <= rx_status;
            bclk_prev   <= bclkx8;
        end else begin
            status_prev <= rx_status;
            bclk_prev   <= bclkx8;
        end
    end

    // Capture FSM: arm on end of frame, load on the next baud tick, abort
    // if the receiver goes busy again first. load_q is the registered write.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            load_q <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (status_fall) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (rx_status) begin
                        state <= IDLE;
                    end else if (bclk_rise) begin
                        state  <= LOAD;
                        load_q <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (sys_clk),
        .rst      (rst),
        .wr       (load_q),
        .wr_data  (RHR),
        .rd_en    (bus.rd_en),
        .clr_ovf  (bus.clr_ovf),
        .rd_data  (bus.rd_data),
        .empty    (bus.empty),
        .full     (bus.full),
        .level    (bus.level),
        .overflow (bus.overflow)
    );

endmodule

// File: tb/tb_rx_buffer.sv
// Bench for rx_buffer: directed frames against a queue-based model of the
// buffer, compared every cycle, plus literal checkpoints.
module tb_rx_buffer;

    localparam int DEPTH = 16;

    logic       sys_clk;
    logic       rst;
    logic       bclkx8;
    logic       rx_status;
    logic [7:0] rhr;
    logic [3:0] bcnt;

    rx_buffer_if #(.DEPTH(DEPTH)) bus ();

    rx_buffer #(.DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .bclkx8    (bclkx8),
        .rx_status (rx_status),
        .RHR       (rhr),
        .bus       (bus)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    bit          checking = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Clock and a free-running 8x tick at sys_clk/16.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        bcnt   = '0;
        bclkx8 = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            bcnt   = bcnt + 4'd1;
            bclkx8 = bcnt[3];
        end
    end

    // Behavioural model: a byte queue plus frame-tracking flags.
    byte unsigned q[$];
    logic [7:0]   m_head = 8'h00;
    bit           m_ovf = 0;
    logic         m_sprev, m_bprev;
    bit           pending = 0, load_next = 0;
    bit           m_pop, m_drop;

    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_head    = 8'h00;
            m_ovf     = 0;
            pending   = 0;
            load_next = 0;
            m_sprev   = rx_status;
            m_bprev   = bclkx8;
        end else begin
            m_pop  = bus.rd_en && (q.size() > 0);
            m_drop = 0;
            if (m_pop) void'(q.pop_front());
            if (load_next) begin
                if (q.size() < DEPTH) q.push_back(rhr);
                else m_drop = 1;
            end
            if (m_drop) m_ovf = 1;
            else if (bus.clr_ovf) m_ovf = 0;
            if (q.size() > 0) m_head = q[0];

            if (load_next) begin
                load_next = 0;
            end else if (pending) begin
                if (rx_status) pending = 0;
                else if (bclkx8 && !m_bprev) begin
                    pending   = 0;
                    load_next = 1;
                end
            end else if (m_sprev && !rx_status) begin
                pending = 1;
            end
            m_sprev = rx_status;
            m_bprev = bclkx8;
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge sys_clk) begin
        if (checking) begin
            check("rd_data",  bus.rd_data,  m_head);
            check("level",    bus.level,    q.size());
            check("empty",    bus.empty,    q.size() == 0);
            check("full",     bus.full,     q.size() == DEPTH);
            check("overflow", bus.overflow, m_ovf);
        end
    end

    // mode 0: plain frame, 1: rd_en at the write edge, 2: clr_ovf at the write edge
    task automatic send_frame(input logic [7:0] b, input int mode);
        bit   found;
        logic b0;
        @(posedge sys_clk); #3;
        rx_status = 1'b1;
        repeat (12) @(posedge sys_clk);
        #3;
        rhr       = b;
        rx_status = 1'b0;
        b0    = bclkx8;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge sys_clk); #2;
            if (bclkx8 && !b0) found = 1;
            b0 = bclkx8;
        end
        if (!found) begin
            n_total++;
            $display("FAIL bclk_wait: got no tick expected tick within 40 cycles");
        end
        if (mode != 0) begin
            @(posedge sys_clk); #1;
            if (mode == 1) bus.rd_en = 1'b1;
            else bus.clr_ovf = 1'b1;
            @(posedge sys_clk); #1;
            bus.rd_en   = 1'b0;
            bus.clr_ovf = 1'b0;
        end
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        @(posedge sys_clk); #1;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rx_status   = 1'b0;
        rhr         = 8'h00;
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        rst         = 1'b1;
        #2 checking = 1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_rd_data", bus.rd_data, 8'h00);
        check("rst_empty",   bus.empty,   1);
        check("rst_full",    bus.full,    0);
        check("rst_level",   bus.level,   0);
        check("rst_ovf",     bus.overflow, 0);
        #2 rst = 1'b0;

        // Single frame.
        send_frame(8'hA5, 0);
        check("a5_data",  bus.rd_data, 8'hA5);
        check("a5_level", bus.level,   1);
        check("a5_empty", bus.empty,   0);
        check("a5_model", q.size(),    1);
        pop_one();
        pop_one();   // pop on empty is ignored
        check("a5_drained", bus.level, 0);

        // Three frames then three pops.
        send_frame(8'h01, 0);
        send_frame(8'h02, 0);
        send_frame(8'h03, 0);
        check("seq_level", bus.level, 3);
        check("seq_d0", bus.rd_data, 8'h01); pop_one();
        check("seq_d1", bus.rd_data, 8'h02); pop_one();
        check("seq_d2", bus.rd_data, 8'h03); pop_one();
        check("seq_empty", bus.empty, 1);
        check("seq_level0", bus.level, 0);
        check("seq_hold", bus.rd_data, 8'h03);

        // Seventeen frames into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 0);
        check("ovf_full",  bus.full,     1);
        check("ovf_level", bus.level,    16);
        check("ovf_flag",  bus.overflow, 1);
        check("ovf_head",  bus.rd_data,  8'h10);
        check("ovf_model", m_ovf,        1);
        bus.clr_ovf = 1'b1;
        @(posedge sys_clk); #1;
        bus.clr_ovf = 1'b0;
        check("ovf_clr", bus.overflow, 0);

        // Drop coincident with clr_ovf keeps the flag set.
        send_frame(8'h21, 2);
        check("ovf_clr_drop", bus.overflow, 1);
        bus.clr_ovf = 1'b1;
        @(posedge sys_clk); #1;
        bus.clr_ovf = 1'b0;
        check("ovf_clr2", bus.overflow, 0);

        // Write and pop together while full.
        send_frame(8'h77, 1);
        check("wp_level", bus.level,    16);
        check("wp_ovf",   bus.overflow, 0);
        check("wp_head",  bus.rd_data,  8'h11);
        bus.rd_en = 1'b1;
        repeat (15) @(posedge sys_clk);
        #1;
        bus.rd_en = 1'b0;
        check("wp_tail",  bus.rd_data, 8'h77);
        check("wp_tail_level", bus.level, 1);
        pop_one();
        check("wp_empty", bus.empty, 1);

        // Reset while ARMED discards the capture.
        @(posedge bclkx8);
        @(posedge sys_clk); #3;
        rx_status = 1'b1;
        repeat (3) @(posedge sys_clk);
        #3;
        rhr       = 8'hEE;
        rx_status = 1'b0;
        repeat (3) @(posedge sys_clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #3 rst = 1'b0;
        repeat (40) @(posedge sys_clk);
        #1;
        check("rarm_empty", bus.empty, 1);
        check("rarm_level", bus.level, 0);
        send_frame(8'h3C, 0);
        check("rarm_data",  bus.rd_data, 8'h3C);
        check("rarm_level1", bus.level,  1);

        // Busy flag drops and returns before a tick: aborted frame.
        @(posedge bclkx8);
        @(posedge sys_clk); #3;
        rx_status = 1'b1;
        repeat (3) @(posedge sys_clk);
        #3 rhr = 8'h99; rx_status = 1'b0;
        repeat (4) @(posedge sys_clk);
        #3 rx_status = 1'b1;
        repeat (30) @(posedge sys_clk);
        #1;
        check("abort_level", bus.level, 1);
        send_frame(8'h5A, 0);
        check("abort_next_level", bus.level, 2);
        check("abort_next_head",  bus.rd_data, 8'h3C);

        repeat (4) @(posedge sys_clk);
        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
